// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default widths for the countdown timer
package timer_pkg;

    localparam int TIMER_N_DEFAULT = 8;
    localparam int TIMER_P_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

endpackage

// File: rtl/prescaler.sv
// rtl/prescaler.sv - P-bit tick generator: one tick every presc+1 enabled cycles
module prescaler
    import timer_pkg::*;
#(
    parameter int P = TIMER_P_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [P-1:0] presc,
    output logic         tick
);

    logic [P-1:0] r_cnt;

    // An equality compare means a presc lowered below r_cnt lets r_cnt run
    // through its natural wrap before the next tick.
    assign tick = en && (r_cnt == presc);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + P'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable prescaled down-counter with one-shot or auto-reload expiry
module countdown_timer
    import timer_pkg::*;
#(
    parameter int N = TIMER_N_DEFAULT,
    parameter int P = TIMER_P_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         reload_en,
    input  logic [P-1:0] presc,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         at_zero,
    output logic         done
);

    timer_state_t r_state;
    timer_state_t w_state_n;
    logic [N-1:0] r_count;
    logic [N-1:0] w_count_n;
    logic [N-1:0] r_reload;
    logic [N-1:0] w_reload_n;
    logic         r_done;
    logic         w_done_n;
    logic         w_tick;
    logic         w_run;
    logic         w_presc_clr;

    assign w_run       = (r_state == RUN);
    assign w_presc_clr = clear || load;

    prescaler #(.P(P)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (w_presc_clr),
        .en    (w_run),
        .presc (presc),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_count  <= w_count_n;
            r_reload <= w_reload_n;
            r_done   <= w_done_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_count_n  = r_count;
        w_reload_n = r_reload;
        w_done_n   = 1'b0;
        if (clear) begin
            w_state_n = IDLE;
            w_count_n = '0;
        end else if (load) begin
            w_state_n  = IDLE;
            w_count_n  = load_val;
            w_reload_n = load_val;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        if (r_count != '0) begin
                            w_state_n = RUN;
                        end else begin
                            w_state_n = DONE;
                            w_done_n  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The tick on a pause edge still counts; the freeze starts after it.
                    if (w_tick) begin
                        if (r_count > N'(1)) begin
                            w_count_n = r_count - N'(1);
                        end else if (reload_en && (r_reload != '0)) begin
                            w_count_n = r_reload;
                            w_done_n  = 1'b1;
                        end else begin
                            w_count_n = '0;
                            w_done_n  = 1'b1;
                            w_state_n = DONE;
                        end
                    end
                    if ((w_state_n == RUN) && pause && !start) begin
                        w_state_n = PAUSED;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        w_state_n = RUN;
                    end
                end
                DONE: begin
                    // Count is zero here, so start only holds; no repeat pulse.
                    if (start && (r_count != '0)) begin
                        w_state_n = RUN;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    assign count   = r_count;
    assign busy    = (r_state == RUN) || (r_state == PAUSED);
    assign at_zero = (r_count == '0);
    assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
module tb_countdown_timer;

    localparam int N = 8;
    localparam int P = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic         clk = 1'b0;
    logic         reset, clear, load, start, pause, reload_en;
    logic [N-1:0] load_val;
    logic [P-1:0] presc;
    logic [N-1:0] count;
    logic         busy, at_zero, done;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt, m_rel, m_ph, m_st, m_dn;

    typedef struct {
        bit rst; bit clr; bit ld; int lv; bit st; bit ps; bit re; int pr;
        int e_cnt; bit e_busy; bit e_done;
    } vec_t;

    vec_t tbl[11];

    countdown_timer #(.N(N), .P(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .pause     (pause),
        .reload_en (reload_en),
        .presc     (presc),
        .count     (count),
        .busy      (busy),
        .at_zero   (at_zero),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit rst, bit clr, bit ld, int lv, bit st, bit ps, bit re, int pr,
                                int ec, bit eb, bit ed);
        vec_t v;
        v.rst = rst; v.clr = clr; v.ld = ld; v.lv = lv; v.st = st; v.ps = ps; v.re = re; v.pr = pr;
        v.e_cnt = ec; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        reset = 0; clear = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in(); reset = 1; cyc(); idle_in();
    endtask

    task automatic do_load(input int v, input int pr, input bit re);
        idle_in(); load = 1; load_val = N'(v); presc = P'(pr); reload_en = re; cyc(); idle_in();
    endtask

    // Reference: counts elapsed enabled cycles in m_ph (mod 2^P) and decrements
    // whenever that phase reaches presc while running.
    task automatic model_step();
        if (reset) begin
            m_cnt = 0; m_rel = 0; m_ph = 0; m_st = M_IDLE; m_dn = 0;
        end else if (clear) begin
            m_cnt = 0; m_ph = 0; m_st = M_IDLE; m_dn = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_rel = int'(load_val); m_ph = 0; m_st = M_IDLE; m_dn = 0;
        end else begin
            m_dn = 0;
            if (m_st == M_IDLE || m_st == M_DONE) begin
                if (start && m_cnt != 0) m_st = M_RUN;
                else if (start && m_st == M_IDLE) begin m_st = M_DONE; m_dn = 1; end
            end else if (m_st == M_PAUSED) begin
                if (start) m_st = M_RUN;
            end else begin
                if (m_ph == int'(presc)) begin
                    m_ph = 0;
                    if (m_cnt > 1) m_cnt = m_cnt - 1;
                    else begin
                        m_dn = 1;
                        if (reload_en && m_rel != 0) m_cnt = m_rel;
                        else begin m_cnt = 0; m_st = M_DONE; end
                    end
                end else begin
                    m_ph = (m_ph + 1) % (1 << P);
                end
                if (m_st == M_RUN && pause && !start) m_st = M_PAUSED;
            end
        end
    endtask

    initial begin
        int first_done, pulses, last_done, bad;
        idle_in(); load_val = '0; presc = '0; reload_en = 0;
        m_cnt = 0; m_rel = 0; m_ph = 0; m_st = M_IDLE; m_dn = 0;

        // Table: reset, one-shot 3..0 with presc 0, load-beats-start, clear, start at zero
        tbl[0]  = mk(1,0,0,0,0,0,0,0, 0,0,0);
        tbl[1]  = mk(0,0,1,3,0,0,0,0, 3,0,0);
        tbl[2]  = mk(0,0,0,0,1,0,0,0, 3,1,0);
        tbl[3]  = mk(0,0,0,0,0,0,0,0, 2,1,0);
        tbl[4]  = mk(0,0,0,0,0,0,0,0, 1,1,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,0, 0,0,1);
        tbl[6]  = mk(0,0,0,0,0,0,0,0, 0,0,0);
        tbl[7]  = mk(0,0,1,7,1,0,0,0, 7,0,0);
        tbl[8]  = mk(0,1,0,0,0,0,0,0, 0,0,0);
        tbl[9]  = mk(0,0,0,0,1,0,0,0, 0,0,1);
        tbl[10] = mk(0,0,0,0,0,0,0,0, 0,0,0);
        for (int i = 0; i < 11; i++) begin
            reset = tbl[i].rst; clear = tbl[i].clr; load = tbl[i].ld; load_val = N'(tbl[i].lv);
            start = tbl[i].st; pause = tbl[i].ps; reload_en = tbl[i].re; presc = P'(tbl[i].pr);
            cyc();
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
            chk($sformatf("tbl%0d_at_zero", i), int'(at_zero), int'(tbl[i].e_cnt == 0));
        end
        idle_in();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("oneshot_hold_count", int'(count), 0);
        end

        // Reset mid-RUN
        do_reset(); do_load(5, 0, 0);
        start = 1; cyc(); idle_in(); cyc(); cyc();
        reset = 1; cyc(); idle_in();
        chk("rst_mid_count", int'(count), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin cyc(); if (done || count != 0) bad++; end
        chk("rst_mid_quiet", bad, 0);

        // Periodic: presc 3, reload 2 -> done every 8 cycles
        do_reset(); do_load(2, 3, 1);
        start = 1; cyc(); idle_in();
        pulses = 0; last_done = -1;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) cyc();
            chk($sformatf("per_count_k%0d", k), int'(count), ((k / 4) % 2 == 0) ? 2 : 1);
            chk($sformatf("per_done_k%0d", k), int'(done), int'(k > 0 && k % 8 == 0));
            if (done) begin
                if (last_done >= 0) chk("per_spacing", k - last_done, 8);
                last_done = k; pulses++;
            end
        end
        chk("per_pulses_ge3", int'(pulses >= 3), 1);

        // Pause/resume: presc 2, load 4, pause edges 4..8, start at edge 9 -> done at edge 17
        do_reset(); do_load(4, 2, 0);
        start = 1; cyc(); idle_in();
        first_done = -1;
        for (int k = 1; k <= 25; k++) begin
            pause = (k >= 4 && k <= 8);
            start = (k == 9);
            cyc(); idle_in();
            if (k >= 4 && k <= 9) chk($sformatf("pause_frozen_k%0d", k), int'(count), 3);
            if (done && first_done < 0) first_done = k;
        end
        chk("pause_done_edge", first_done, 17);
        chk("pause_end_busy", int'(busy), 0);

        // Clear during RUN, then start at zero -> DONE with a single pulse
        do_reset(); do_load(5, 0, 1);
        start = 1; cyc(); idle_in(); cyc(); cyc();
        clear = 1; cyc(); idle_in();
        chk("clr_count", int'(count), 0);
        chk("clr_busy", int'(busy), 0);
        start = 1; cyc(); idle_in();
        chk("clr_start_done", int'(done), 1);
        chk("clr_start_busy", int'(busy), 0);
        cyc();
        chk("clr_start_done_once", int'(done), 0);

        // Randomized run against the reference model
        do_reset();
        m_cnt = 0; m_rel = 0; m_ph = 0; m_st = M_IDLE; m_dn = 0;
        presc = '0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 59) == 0);
            load = ($urandom_range(0, 19) == 0);
            load_val = N'($urandom_range(0, 6));
            start = ($urandom_range(0, 5) == 0);
            pause = ($urandom_range(0, 11) == 0);
            reload_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) presc = P'($urandom_range(0, 3));
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_count", int'(count), m_cnt);
            chk("rnd_busy", int'(busy), int'(m_st == M_RUN || m_st == M_PAUSED));
            chk("rnd_at_zero", int'(at_zero), int'(m_cnt == 0));
            chk("rnd_done", int'(done), m_dn);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter/timer: the decrementing counterpart to the team's up-counter.
- Software/top logic loads a start value, starts it, and the block decrements once per prescaled tick. It flags expiry with a one-cycle done pulse.
- Optional auto-reload turns it into a periodic tick generator.
- Sits beside the up-counter in the FPGA test tops, driven from pb[] and showing count on the LEDs or seven-segment displays.

Parameters:
- N, 8, count width; maximum load value 2^N - 1.
- P, 4, prescaler width; up to 2^P cycles per decrement.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- clear  input  1  synchronous clear: count, prescaler and state go to idle values
- load  input  1  capture load_val into count and reload register
- load_val  input  N  value to load
- start  input  1  begin or resume counting
- pause  input  1  hold count and prescaler
- reload_en  input  1  1: restart from the reload register at expiry; 0: stop at 0
- presc  input  P  clock cycles per decrement, minus 1
- count  output  N  current count
- busy  output  1  1 in RUN or PAUSED
- at_zero  output  1  combinational (count == 0)
- done  output  1  one-cycle registered expiry pulse

Behaviour:
- Reset values (reset sampled high at a clk edge):
  - count = 0, reload register = 0, prescaler = 0
  - state = IDLE, busy = 0, done = 0
- Reset takes effect mid-operation with no residual pulse.
- Input priority each cycle: reset > clear > load > start > pause.
- clear: same effect as reset, except the reload register is kept.
- load, in any state:
  - count and reload register <= load_val; prescaler <= 0
  - state <= IDLE; done <= 0
- States and transitions:
  - IDLE, start, count != 0: go to RUN.
  - IDLE, start, count == 0: go to DONE; done = 1 next cycle.
  - RUN, pause: go to PAUSED; prescaler and count frozen.
  - RUN, expiry tick, reload_en = 0: go to DONE.
  - RUN, expiry tick, reload_en = 1: stay in RUN.
  - PAUSED, start: go to RUN; prescaler continues from its frozen value.
  - PAUSED, start and pause in the same cycle: start wins.
  - DONE, start: same as start from IDLE, using the current count. Effectively a no-op unless count was reloaded.
  - DONE: otherwise hold; count = 0.
- Prescaler, in RUN only:
  - tick = (prescaler == presc).
  - On tick the prescaler wraps to 0; otherwise it increments.
  - presc = 0 gives a decrement every cycle.
  - presc changed mid-run takes effect at the next compare. If the new presc is below the current prescaler value, the prescaler counts up to 2^P - 1, wraps to 0 and continues. No extra decrement occurs.
- Decrement on tick:
  - count > 1: count - 1.
  - count == 1, reload_en = 0: count <= 0; done <= 1; state <= DONE.
  - count == 1, reload_en = 1, reload register != 0: count <= reload register; done <= 1; stay in RUN.
  - count == 1, reload_en = 1, reload register == 0: treated as reload_en = 0.
  - count never underflows.
- Latency: from the start edge, the first decrement occurs presc+1 cycles later.
  - Expiry period = L*(presc+1) cycles, where L is the loaded value.
  - done is asserted on the same edge that count changes from 1 to 0 (or reloads).
- reload_en is sampled at the expiry tick only.
- done is high for exactly one cycle per expiry, never in back-to-back cycles unless presc = 0 and reload register = 1.

Decomposition:
- Shared package timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, PAUSED, DONE}
  - localparam defaults for N and P
- One sub-module: prescaler (P-bit tick generator) with ports clk, reset, clr, en, presc, tick.
- The state machine and count register stay in countdown_timer.

Test Plan:
- Reset mid-RUN:
  - load 5, start, then assert reset after 2 cycles.
  - count = 0, busy = 0, done = 0 on the next cycle; no done pulse afterwards.
- One-shot, presc = 0, reload_en = 0:
  - load 3, start.
  - count reads 3, 2, 1, 0 on successive cycles.
  - done = 1 exactly on the cycle count becomes 0; state DONE; count stays 0 for 10 cycles.
- Prescaled periodic, presc = 3, reload_en = 1:
  - load 2, start.
  - done pulses every 8 cycles, at least 3 times; count cycles 2, 1, 2, 1 with 4 cycles per value.
- Pause/resume:
  - presc = 2, load 4, start; pause after 4 cycles for 5 cycles; then start.
  - count and prescaler are frozen while paused; total time to done = 12 + 5 cycles.
- Corner cases:
  - start with count = 0: done pulses once, state DONE.
  - load 7 asserted together with start: load wins; state IDLE, count = 7.
  - clear during RUN: count = 0, reload register retained. A following start with reload_en = 1 and count 0 goes straight to DONE with one done pulse.
